// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling stage; 256 read-read-write-write swap iterations over the shared S memory.
module ksa #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);
    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_J, WR_I} state_t;

    state_t                 state_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i_q, j_q, si_q, sj_q, addr_q, wrdata_q, j_d;
    logic [KW-1:0]          kidx_q;
    logic                   rdy_q, wren_q;
    logic [7:0]             kbyte [KEY_BYTES];

    // Byte 0 is the most significant byte of the key.
    for (genvar g = 0; g < KEY_BYTES; g++) begin : g_kbyte
        assign kbyte[g] = key_q[8*(KEY_BYTES-g)-1 -: 8];
    end

    assign j_d    = j_q + rddata + kbyte[kidx_q];
    assign rdy    = rdy_q;
    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            kidx_q   <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            rdy_q    <= 1'b1;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    key_q   <= key;
                    i_q     <= '0;
                    j_q     <= '0;
                    kidx_q  <= '0;
                    rdy_q   <= 1'b0;
                    addr_q  <= '0;
                    state_q <= RD_I;
                end
                RD_I: state_q <= WAIT_I;
                WAIT_I: begin
                    si_q    <= rddata;
                    j_q     <= j_d;
                    addr_q  <= j_d;
                    state_q <= RD_J;
                end
                RD_J: state_q <= WAIT_J;
                // Both reads complete before either write, so i==j leaves S unchanged.
                WAIT_J: begin
                    sj_q     <= rddata;
                    wrdata_q <= si_q;
                    wren_q   <= 1'b1;
                    state_q  <= WR_J;
                end
                WR_J: begin
                    addr_q   <= i_q;
                    wrdata_q <= sj_q;
                    state_q  <= WR_I;
                end
                WR_I: begin
                    wren_q <= 1'b0;
                    i_q    <= i_q + 8'd1;
                    kidx_q <= (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
                    if (i_q == 8'hFF) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        addr_q  <= i_q + 8'd1;
                        state_q <= RD_I;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ksa.sv
// tb_ksa: directed and randomized checks of ksa against a software KSA model and a behavioural S memory.
module tb_ksa;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy, wren;
    logic [23:0] key = '0;
    logic [7:0]  addr, wrdata;
    logic [7:0]  rddata = '0;
    logic [7:0]  mem [256];
    logic [7:0]  ref_s [256];
    logic [15:0] ew [$];
    logic [15:0] wl [$];
    int          total = 0;
    int          fails = 0;

    ksa #(.KEY_BYTES(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data for the address sampled at an edge is valid until the next edge.
    always @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wrdata;
            wl.push_back({addr, wrdata});
        end
        rddata <= mem[addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference KSA on ref_s; records the expected write pairs (addr,data) in order.
    task automatic model(input logic [23:0] k);
        logic [7:0] j, t;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + ref_s[i] + k[23-8*(i%3) -: 8];
            ew.push_back({j, ref_s[i]});
            ew.push_back({8'(i), ref_s[j]});
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic load_identity();
        for (int k = 0; k < 256; k++) begin
            ref_s[k] = 8'(k);
            mem[k] <= 8'(k);
        end
    endtask

    task automatic load_random();
        logic [7:0] t;
        int r;
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
        for (int k = 255; k > 0; k--) begin
            r = $urandom_range(k, 0);
            t = ref_s[k];
            ref_s[k] = ref_s[r];
            ref_s[r] = t;
        end
        for (int k = 0; k < 256; k++) mem[k] <= ref_s[k];
    endtask

    task automatic verify(input string tag, input int n);
        int bad;
        check({tag, "_nwr"}, wl.size(), n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_wr%0d", tag, k), (k < wl.size()) ? wl[k] : 16'hxxxx, ew[k]);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    task automatic run(input string tag, input logic [23:0] k, input bit poke);
        int n;
        ew.delete();
        model(k);
        @(negedge clk);
        wl.delete();
        en = 1'b1;
        key = k;
        @(negedge clk);
        en = 1'b0;
        key = 24'($urandom);
        check({tag, "_first_addr"}, addr, 8'h00);
        n = 0;
        while (!rdy && n < 2000) begin
            n++;
            en = poke && (n % 97 == 5);
            key = 24'($urandom);
            @(negedge clk);
        end
        en = 1'b0;
        check({tag, "_busy_cycles"}, n, 1536);
        verify(tag, 512);
    endtask

    initial begin
        int n1, n2, h;
        logic [23:0] k;
        load_identity();
        repeat (4) begin
            @(negedge clk);
            en = ~en;
        end
        check("rst_rdy", rdy, 1'b1);
        check("rst_wren", wren, 1'b0);
        check("rst_addr", addr, 8'h00);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_quiet", wl.size(), 0);
        check("idle_rdy", rdy, 1'b1);

        load_identity();
        run("k000000", 24'h000000, 1'b0);
        check("k0_it0", wl[0], 16'h0000);
        check("k0_it1", wl[2], 16'h0101);
        check("k0_it2a", wl[4], 16'h0302);
        check("k0_it2b", wl[5], 16'h0203);

        load_identity();
        run("k010203", 24'h010203, 1'b0);
        check("k123_w0", wl[0], 16'h0100);
        check("k123_w1", wl[1], 16'h0001);
        check("k123_w2", wl[2], 16'h0300);
        check("k123_w3", wl[3], 16'h0103);

        load_identity();
        run("kffffff", 24'hFFFFFF, 1'b0);
        check("kff_w0", wl[0], 16'hFF00);
        check("kff_w1", wl[1], 16'h00FF);

        repeat (3) begin
            load_random();
            run("rand", 24'($urandom), 1'b1);
        end

        // en held high: two back-to-back runs separated by one idle cycle.
        load_identity();
        k = 24'($urandom);
        ew.delete();
        model(k);
        model(k);
        @(negedge clk);
        wl.delete();
        en = 1'b1;
        key = k;
        @(negedge clk);
        n1 = 0;
        while (!rdy && n1 < 2000) begin n1++; @(negedge clk); end
        h = 0;
        while (rdy && h < 10) begin h++; @(negedge clk); end
        en = 1'b0;
        n2 = 0;
        while (!rdy && n2 < 2000) begin n2++; @(negedge clk); end
        check("b2b_run1", n1, 1536);
        check("b2b_idle", h, 1);
        check("b2b_run2", n2, 1536);
        verify("b2b", 1024);

        // Asynchronous reset partway through a run.
        load_identity();
        @(negedge clk);
        en = 1'b1;
        key = 24'($urandom);
        @(negedge clk);
        en = 1'b0;
        repeat (699) @(negedge clk);
        check("mid_busy", rdy, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy", rdy, 1'b1);
        check("arst_wren", wren, 1'b0);
        check("arst_addr", addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        load_identity();
        run("after_rst", 24'($urandom), 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
